// File: rtl/nbody_bus_packer.sv
// Host bus front end for the n-body accelerator: control registers, 32->64-bit body RAM
// write assembly, and shadowed 64-bit result readback from the position RAM.
module nbody_bus_packer #(
    parameter int unsigned BODY_ADDR_WIDTH = 9,
    parameter int unsigned ADDR_WIDTH      = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       chipselect,
    input  logic                       write,
    input  logic                       read,
    input  logic [ADDR_WIDTH-1:0]      addr,
    input  logic [31:0]                writedata,
    output logic [31:0]                readdata,
    output logic                       waitrequest,
    output logic                       go,
    output logic                       read_mode,
    output logic [15:0]                n_bodies,
    output logic [31:0]                gap,
    output logic                       mem_we,
    output logic [2:0]                 mem_sel,
    output logic [BODY_ADDR_WIDTH-1:0] mem_idx,
    output logic [63:0]                mem_wdata,
    input  logic                       done,
    output logic                       rd_req,
    output logic                       rd_sel,
    output logic [BODY_ADDR_WIDTH-1:0] rd_idx,
    input  logic [63:0]                rd_data,
    input  logic                       rd_valid,
    output logic                       err
);

    localparam int unsigned SEL_W  = ADDR_WIDTH - BODY_ADDR_WIDTH;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned DBL_W  = 64;
    localparam int unsigned NB_W   = 16;
    localparam int unsigned FLD_W  = 3;

    localparam logic [SEL_W-1:0] SEL_GO    = SEL_W'(32'h00);
    localparam logic [SEL_W-1:0] SEL_READ  = SEL_W'(32'h01);
    localparam logic [SEL_W-1:0] SEL_NB    = SEL_W'(32'h02);
    localparam logic [SEL_W-1:0] SEL_GAP   = SEL_W'(32'h03);
    localparam logic [SEL_W-1:0] SEL_X_LO  = SEL_W'(32'h04);
    localparam logic [SEL_W-1:0] SEL_X_HI  = SEL_W'(32'h05);
    localparam logic [SEL_W-1:0] SEL_Y_LO  = SEL_W'(32'h06);
    localparam logic [SEL_W-1:0] SEL_Y_HI  = SEL_W'(32'h07);
    localparam logic [SEL_W-1:0] SEL_VX_LO = SEL_W'(32'h08);
    localparam logic [SEL_W-1:0] SEL_VX_HI = SEL_W'(32'h09);
    localparam logic [SEL_W-1:0] SEL_VY_LO = SEL_W'(32'h10);
    localparam logic [SEL_W-1:0] SEL_VY_HI = SEL_W'(32'h11);
    localparam logic [SEL_W-1:0] SEL_M_LO  = SEL_W'(32'h12);
    localparam logic [SEL_W-1:0] SEL_M_HI  = SEL_W'(32'h13);
    localparam logic [SEL_W-1:0] SEL_DONE  = SEL_W'(32'h40);
    localparam logic [SEL_W-1:0] SEL_RX_LO = SEL_W'(32'h41);
    localparam logic [SEL_W-1:0] SEL_RX_HI = SEL_W'(32'h42);
    localparam logic [SEL_W-1:0] SEL_RY_LO = SEL_W'(32'h43);
    localparam logic [SEL_W-1:0] SEL_RY_HI = SEL_W'(32'h44);

    localparam logic [FLD_W-1:0] FLD_X  = FLD_W'(0);
    localparam logic [FLD_W-1:0] FLD_Y  = FLD_W'(1);
    localparam logic [FLD_W-1:0] FLD_VX = FLD_W'(2);
    localparam logic [FLD_W-1:0] FLD_VY = FLD_W'(3);
    localparam logic [FLD_W-1:0] FLD_M  = FLD_W'(4);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    state_t                     state_q, state_d;
    logic                       go_q, go_d;
    logic                       read_mode_q, read_mode_d;
    logic [NB_W-1:0]            n_bodies_q, n_bodies_d;
    logic [WORD_W-1:0]          gap_q, gap_d;
    logic                       err_q, err_d;
    logic                       staged_v_q, staged_v_d;
    logic [WORD_W-1:0]          stage_lo_q, stage_lo_d;
    logic [FLD_W-1:0]           stage_fld_q, stage_fld_d;
    logic [BODY_ADDR_WIDTH-1:0] stage_idx_q, stage_idx_d;
    logic                       mem_we_q, mem_we_d;
    logic [FLD_W-1:0]           mem_sel_q, mem_sel_d;
    logic [BODY_ADDR_WIDTH-1:0] mem_idx_q, mem_idx_d;
    logic [DBL_W-1:0]           mem_wdata_q, mem_wdata_d;
    logic                       rd_req_q, rd_req_d;
    logic                       rd_sel_q, rd_sel_d;
    logic [BODY_ADDR_WIDTH-1:0] rd_idx_q, rd_idx_d;
    logic                       req_hi_q, req_hi_d;
    logic                       shadow_v_q, shadow_v_d;
    logic                       shadow_sel_q, shadow_sel_d;
    logic [BODY_ADDR_WIDTH-1:0] shadow_idx_q, shadow_idx_d;
    logic [DBL_W-1:0]           shadow_data_q, shadow_data_d;

    logic [SEL_W-1:0]           sel;
    logic [BODY_ADDR_WIDTH-1:0] idx;
    logic                       wr_en, rd_en;
    logic                       body_lo, body_hi;
    logic [FLD_W-1:0]           fld;
    logic                       res_rd, res_hi, res_y;
    logic                       shadow_hit;

    assign sel   = addr[ADDR_WIDTH-1:BODY_ADDR_WIDTH];
    assign idx   = addr[BODY_ADDR_WIDTH-1:0];
    assign wr_en = chipselect && write;
    assign rd_en = chipselect && read && !write;

    // Address select decode into body-RAM halves and result-read halves
    always_comb begin
        body_lo = 1'b0;
        body_hi = 1'b0;
        fld     = FLD_X;
        res_rd  = 1'b0;
        res_hi  = 1'b0;
        res_y   = 1'b0;
        case (sel)
            SEL_X_LO:  begin body_lo = 1'b1; fld = FLD_X;  end
            SEL_X_HI:  begin body_hi = 1'b1; fld = FLD_X;  end
            SEL_Y_LO:  begin body_lo = 1'b1; fld = FLD_Y;  end
            SEL_Y_HI:  begin body_hi = 1'b1; fld = FLD_Y;  end
            SEL_VX_LO: begin body_lo = 1'b1; fld = FLD_VX; end
            SEL_VX_HI: begin body_hi = 1'b1; fld = FLD_VX; end
            SEL_VY_LO: begin body_lo = 1'b1; fld = FLD_VY; end
            SEL_VY_HI: begin body_hi = 1'b1; fld = FLD_VY; end
            SEL_M_LO:  begin body_lo = 1'b1; fld = FLD_M;  end
            SEL_M_HI:  begin body_hi = 1'b1; fld = FLD_M;  end
            SEL_RX_LO: begin res_rd = 1'b1; end
            SEL_RX_HI: begin res_rd = 1'b1; res_hi = 1'b1; end
            SEL_RY_LO: begin res_rd = 1'b1; res_y = 1'b1; end
            SEL_RY_HI: begin res_rd = 1'b1; res_y = 1'b1; res_hi = 1'b1; end
            default: ;
        endcase
    end

    assign shadow_hit = res_hi && shadow_v_q && (shadow_sel_q == res_y) && (shadow_idx_q == idx);

    // Next-state: register writes, half pairing, shadow upkeep and readback FSM
    always_comb begin
        state_d       = state_q;
        go_d          = go_q;
        read_mode_d   = read_mode_q;
        n_bodies_d    = n_bodies_q;
        gap_d         = gap_q;
        err_d         = err_q;
        staged_v_d    = staged_v_q;
        stage_lo_d    = stage_lo_q;
        stage_fld_d   = stage_fld_q;
        stage_idx_d   = stage_idx_q;
        mem_we_d      = 1'b0;
        mem_sel_d     = mem_sel_q;
        mem_idx_d     = mem_idx_q;
        mem_wdata_d   = mem_wdata_q;
        rd_req_d      = 1'b0;
        rd_sel_d      = rd_sel_q;
        rd_idx_d      = rd_idx_q;
        req_hi_d      = req_hi_q;
        shadow_v_d    = shadow_v_q;
        shadow_sel_d  = shadow_sel_q;
        shadow_idx_d  = shadow_idx_q;
        shadow_data_d = shadow_data_q;

        if (wr_en) begin
            case (sel)
                SEL_GO: begin
                    go_d = writedata[0];
                    if (writedata[31]) err_d = 1'b0;
                end
                SEL_READ: read_mode_d = writedata[0];
                SEL_NB:   n_bodies_d  = writedata[NB_W-1:0];
                SEL_GAP:  gap_d       = writedata;
                default: ;
            endcase

            // Body RAMs belong to the core while it runs
            if ((body_lo || body_hi) && go_q) begin
                err_d = 1'b1;
            end else if (body_lo) begin
                staged_v_d  = 1'b1;
                stage_lo_d  = writedata;
                stage_fld_d = fld;
                stage_idx_d = idx;
            end else if (body_hi) begin
                staged_v_d = 1'b0;
                if (staged_v_q && (stage_fld_q == fld) && (stage_idx_q == idx)) begin
                    mem_we_d    = 1'b1;
                    mem_sel_d   = fld;
                    mem_idx_d   = idx;
                    mem_wdata_d = {writedata, stage_lo_q};
                end else begin
                    err_d = 1'b1;
                end
            end
        end

        if ((read_mode_q && !read_mode_d) || (!go_q && go_d)) shadow_v_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (rd_en && res_rd && read_mode_q && !shadow_hit) begin
                    rd_req_d = 1'b1;
                    rd_sel_d = res_y;
                    rd_idx_d = idx;
                    req_hi_d = res_hi;
                    state_d  = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (rd_valid) begin
                    shadow_v_d    = 1'b1;
                    shadow_sel_d  = rd_sel_q;
                    shadow_idx_d  = rd_idx_q;
                    shadow_data_d = rd_data;
                    state_d       = ST_RESP;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Bus read mux: registers answer immediately, result misses stall until RESP
    always_comb begin
        readdata    = '0;
        waitrequest = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rd_en) begin
                    case (sel)
                        SEL_GO:   readdata = WORD_W'(go_q);
                        SEL_READ: readdata = WORD_W'(read_mode_q);
                        SEL_NB:   readdata = WORD_W'(n_bodies_q);
                        SEL_GAP:  readdata = gap_q;
                        SEL_DONE: readdata = WORD_W'(done);
                        default: begin
                            if (res_rd && read_mode_q) begin
                                if (shadow_hit) readdata = shadow_data_q[DBL_W-1:WORD_W];
                                else            waitrequest = 1'b1;
                            end
                        end
                    endcase
                end
            end
            ST_FETCH: waitrequest = 1'b1;
            ST_RESP: begin
                if (rd_en) readdata = req_hi_q ? shadow_data_q[DBL_W-1:WORD_W]
                                               : shadow_data_q[WORD_W-1:0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            go_q          <= 1'b0;
            read_mode_q   <= 1'b0;
            n_bodies_q    <= '0;
            gap_q         <= '0;
            err_q         <= 1'b0;
            staged_v_q    <= 1'b0;
            stage_lo_q    <= '0;
            stage_fld_q   <= '0;
            stage_idx_q   <= '0;
            mem_we_q      <= 1'b0;
            mem_sel_q     <= '0;
            mem_idx_q     <= '0;
            mem_wdata_q   <= '0;
            rd_req_q      <= 1'b0;
            rd_sel_q      <= 1'b0;
            rd_idx_q      <= '0;
            req_hi_q      <= 1'b0;
            shadow_v_q    <= 1'b0;
            shadow_sel_q  <= 1'b0;
            shadow_idx_q  <= '0;
            shadow_data_q <= '0;
        end else begin
            state_q       <= state_d;
            go_q          <= go_d;
            read_mode_q   <= read_mode_d;
            n_bodies_q    <= n_bodies_d;
            gap_q         <= gap_d;
            err_q         <= err_d;
            staged_v_q    <= staged_v_d;
            stage_lo_q    <= stage_lo_d;
            stage_fld_q   <= stage_fld_d;
            stage_idx_q   <= stage_idx_d;
            mem_we_q      <= mem_we_d;
            mem_sel_q     <= mem_sel_d;
            mem_idx_q     <= mem_idx_d;
            mem_wdata_q   <= mem_wdata_d;
            rd_req_q      <= rd_req_d;
            rd_sel_q      <= rd_sel_d;
            rd_idx_q      <= rd_idx_d;
            req_hi_q      <= req_hi_d;
            shadow_v_q    <= shadow_v_d;
            shadow_sel_q  <= shadow_sel_d;
            shadow_idx_q  <= shadow_idx_d;
            shadow_data_q <= shadow_data_d;
        end
    end

    assign go        = go_q;
    assign read_mode = read_mode_q;
    assign n_bodies  = n_bodies_q;
    assign gap       = gap_q;
    assign err       = err_q;
    assign mem_we    = mem_we_q;
    assign mem_sel   = mem_sel_q;
    assign mem_idx   = mem_idx_q;
    assign mem_wdata = mem_wdata_q;
    assign rd_req    = rd_req_q;
    assign rd_sel    = rd_sel_q;
    assign rd_idx    = rd_idx_q;

endmodule

// File: tb/tb_nbody_bus_packer.sv
// Self-checking bench for nbody_bus_packer: register table, commit table with a
// scoreboard of expected RAM commits, and hand sequences for readback and reset corners.
module tb_nbody_bus_packer;

    localparam logic [6:0] SEL_GO    = 7'h00;
    localparam logic [6:0] SEL_READ  = 7'h01;
    localparam logic [6:0] SEL_NB    = 7'h02;
    localparam logic [6:0] SEL_GAP   = 7'h03;
    localparam logic [6:0] SEL_X_LO  = 7'h04;
    localparam logic [6:0] SEL_X_HI  = 7'h05;
    localparam logic [6:0] SEL_Y_HI  = 7'h07;
    localparam logic [6:0] SEL_VX_LO = 7'h08;
    localparam logic [6:0] SEL_VX_HI = 7'h09;
    localparam logic [6:0] SEL_M_HI  = 7'h13;
    localparam logic [6:0] SEL_DONE  = 7'h40;
    localparam logic [6:0] SEL_RX_LO = 7'h41;
    localparam logic [6:0] SEL_RX_HI = 7'h42;
    localparam logic [6:0] SEL_RY_LO = 7'h43;
    localparam logic [6:0] SEL_RY_HI = 7'h44;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        chipselect = 1'b0;
    logic        write = 1'b0;
    logic        read = 1'b0;
    logic [15:0] addr = '0;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic        waitrequest;
    logic        go;
    logic        read_mode;
    logic [15:0] n_bodies;
    logic [31:0] gap;
    logic        mem_we;
    logic [2:0]  mem_sel;
    logic [8:0]  mem_idx;
    logic [63:0] mem_wdata;
    logic        done = 1'b0;
    logic        rd_req;
    logic        rd_sel;
    logic [8:0]  rd_idx;
    logic [63:0] rd_data = '0;
    logic        rd_valid;
    logic        err;

    int checks = 0;
    int errors = 0;
    int rd_req_cnt = 0;
    logic       last_rd_sel = 1'b0;
    logic [8:0] last_rd_idx = '0;

    typedef struct packed {
        logic [2:0]  sel;
        logic [8:0]  idx;
        logic [63:0] data;
    } commit_t;

    typedef struct {
        logic [6:0]  sel;
        logic [31:0] wdata;
        logic [31:0] exp;
    } reg_vec_t;

    typedef struct {
        logic [2:0]  fld;
        logic [8:0]  idx;
        logic [31:0] lo;
        logic [31:0] hi;
    } cm_vec_t;

    commit_t     exp_q[$];
    logic [31:0] rd_exp_q[$];

    nbody_bus_packer dut (
        .clk(clk), .rst(rst), .chipselect(chipselect), .write(write), .read(read),
        .addr(addr), .writedata(writedata), .readdata(readdata), .waitrequest(waitrequest),
        .go(go), .read_mode(read_mode), .n_bodies(n_bodies), .gap(gap),
        .mem_we(mem_we), .mem_sel(mem_sel), .mem_idx(mem_idx), .mem_wdata(mem_wdata),
        .done(done), .rd_req(rd_req), .rd_sel(rd_sel), .rd_idx(rd_idx),
        .rd_data(rd_data), .rd_valid(rd_valid), .err(err)
    );

    always #5 clk = ~clk;

    // Result RAM model: answers exactly one cycle after each request
    always @(posedge clk or negedge rst) begin
        if (!rst) rd_valid <= 1'b0;
        else      rd_valid <= rd_req;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst && rd_req) begin
            rd_req_cnt++;
            last_rd_sel = rd_sel;
            last_rd_idx = rd_idx;
        end
    end

    // Commit scoreboard: every mem_we pulse must match the oldest expected commit
    always @(negedge clk) begin
        if (rst && mem_we) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_commit: sel=%0d idx=%0d data=0x%0h", mem_sel, mem_idx, mem_wdata);
            end else begin
                commit_t e;
                e = exp_q.pop_front();
                chk("commit_sel", 64'(mem_sel), 64'(e.sel));
                chk("commit_idx", 64'(mem_idx), 64'(e.idx));
                chk("commit_data", mem_wdata, e.data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [6:0] sel, input logic [8:0] idx, input logic [31:0] data);
        chipselect = 1'b1; write = 1'b1; read = 1'b0;
        addr = {sel, idx}; writedata = data;
        tick();
        chipselect = 1'b0; write = 1'b0;
    endtask

    task automatic bus_read(input string name, input logic [6:0] sel, input logic [8:0] idx,
                            input logic [31:0] exp, input int exp_waits);
        int waits = 0;
        bit got = 1'b0;
        logic [31:0] e;
        rd_exp_q.push_back(exp);
        chipselect = 1'b1; read = 1'b1; write = 1'b0; addr = {sel, idx};
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (!waitrequest) begin
                e = rd_exp_q.pop_front();
                chk({name, "_data"}, 64'(readdata), 64'(e));
                got = 1'b1;
            end else begin
                waits++;
            end
            tick();
        end
        chipselect = 1'b0; read = 1'b0;
        if (!got) begin
            void'(rd_exp_q.pop_front());
            checks++;
            errors++;
            $display("FAIL %s_timeout: waitrequest still high after %0d cycles", name, waits);
        end else begin
            chk({name, "_waits"}, 64'(waits), 64'(exp_waits));
        end
    endtask

    function automatic logic [31:0] port_of(input logic [6:0] sel);
        case (sel)
            SEL_GO:   return {31'b0, go};
            SEL_READ: return {31'b0, read_mode};
            SEL_NB:   return {16'b0, n_bodies};
            default:  return gap;
        endcase
    endfunction

    function automatic logic [6:0] lo_sel(input logic [2:0] f);
        case (f)
            3'd0:    return 7'h04;
            3'd1:    return 7'h06;
            3'd2:    return 7'h08;
            3'd3:    return 7'h10;
            default: return 7'h12;
        endcase
    endfunction

    task automatic clear_err();
        bus_write(SEL_GO, 9'd0, 32'h8000_0000);
        chk("err_clear", 64'(err), 64'd0);
    endtask

    initial begin
        reg_vec_t rv[8];
        cm_vec_t  cv[5];
        int base;

        rv[0] = '{SEL_NB,   32'd25,        32'd25};
        rv[1] = '{SEL_GAP,  32'd6,         32'd6};
        rv[2] = '{SEL_GO,   32'd1,         32'd1};
        rv[3] = '{SEL_GO,   32'd0,         32'd0};
        rv[4] = '{SEL_READ, 32'd1,         32'd1};
        rv[5] = '{SEL_READ, 32'd0,         32'd0};
        rv[6] = '{SEL_NB,   32'hFFFF_1234, 32'h0000_1234};
        rv[7] = '{SEL_GAP,  32'hDEAD_BEEF, 32'hDEAD_BEEF};

        cv[0] = '{3'd0, 9'd3,   32'h0000_0000, 32'h3FF0_0000};
        cv[1] = '{3'd1, 9'd5,   32'h1111_1111, 32'h2222_2222};
        cv[2] = '{3'd2, 9'd2,   32'hCAFE_F00D, 32'h1234_5678};
        cv[3] = '{3'd3, 9'd511, 32'hFFFF_FFFF, 32'h8000_0000};
        cv[4] = '{3'd4, 9'd0,   32'hA5A5_A5A5, 32'h5A5A_5A5A};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_go", 64'(go), 64'd0);
        chk("rst_read_mode", 64'(read_mode), 64'd0);
        chk("rst_n_bodies", 64'(n_bodies), 64'd0);
        chk("rst_gap", 64'(gap), 64'd0);
        chk("rst_mem_we", 64'(mem_we), 64'd0);
        chk("rst_rd_req", 64'(rd_req), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_waitrequest", 64'(waitrequest), 64'd0);
        chk("rst_readdata", 64'(readdata), 64'd0);
        rst = 1'b1;
        tick();

        // Control registers: port one cycle after write, then same-cycle readback
        for (int i = 0; i < 8; i++) begin
            bus_write(rv[i].sel, 9'd0, rv[i].wdata);
            chk($sformatf("reg_port_%0d", i), 64'(port_of(rv[i].sel)), 64'(rv[i].exp));
            bus_read($sformatf("reg_rd_%0d", i), rv[i].sel, 9'd0, rv[i].exp, 0);
        end

        // Paired half writes commit one double each
        for (int i = 0; i < 5; i++) begin
            bus_write(lo_sel(cv[i].fld), cv[i].idx, cv[i].lo);
            exp_q.push_back('{cv[i].fld, cv[i].idx, {cv[i].hi, cv[i].lo}});
            bus_write(lo_sel(cv[i].fld) + 7'd1, cv[i].idx, cv[i].hi);
            chk($sformatf("commit_err_%0d", i), 64'(err), 64'd0);
        end

        // A second LOWER replaces the staged half without error
        bus_write(SEL_X_LO, 9'd4, 32'h0000_0001);
        bus_write(SEL_X_LO, 9'd6, 32'h0000_0002);
        exp_q.push_back('{3'd0, 9'd6, 64'h0000_0003_0000_0002});
        bus_write(SEL_X_HI, 9'd6, 32'h0000_0003);
        chk("restage_err", 64'(err), 64'd0);

        // Orphan / mismatched UPPER halves
        bus_write(SEL_Y_HI, 9'd5, 32'h1234_0000);
        chk("orphan_hi_err", 64'(err), 64'd1);
        clear_err();
        bus_write(SEL_VX_LO, 9'd2, 32'h0000_00AA);
        bus_write(SEL_M_HI, 9'd2, 32'h0000_00BB);
        chk("field_mismatch_err", 64'(err), 64'd1);
        clear_err();
        bus_write(SEL_VX_HI, 9'd2, 32'h0000_00CC);
        chk("stage_cleared_err", 64'(err), 64'd1);
        clear_err();
        bus_write(SEL_X_LO, 9'd1, 32'h0000_0011);
        bus_write(SEL_X_HI, 9'd9, 32'h0000_0022);
        chk("idx_mismatch_err", 64'(err), 64'd1);
        clear_err();

        // Body writes while running are rejected
        bus_write(SEL_GO, 9'd0, 32'd1);
        bus_write(SEL_X_LO, 9'd8, 32'h0000_0055);
        chk("go_write_err", 64'(err), 64'd1);
        bus_write(SEL_GO, 9'd0, 32'h8000_0000);
        chk("go_clr_err", 64'(err), 64'd0);
        chk("go_clr_go", 64'(go), 64'd0);
        bus_write(SEL_X_HI, 9'd8, 32'h0000_0066);
        chk("go_lo_not_staged", 64'(err), 64'd1);
        clear_err();

        // Result readback: miss then shadow hit
        bus_write(SEL_READ, 9'd0, 32'd1);
        rd_data = 64'h4034_0000_0000_0000;
        base = rd_req_cnt;
        bus_read("x_lo_b2", SEL_RX_LO, 9'd2, 32'h0000_0000, 3);
        chk("x_lo_b2_reqs", 64'(rd_req_cnt - base), 64'd1);
        chk("x_lo_b2_rd_sel", 64'(last_rd_sel), 64'd0);
        chk("x_lo_b2_rd_idx", 64'(last_rd_idx), 64'd2);
        bus_read("x_hi_b2", SEL_RX_HI, 9'd2, 32'h4034_0000, 0);
        chk("x_hi_b2_reqs", 64'(rd_req_cnt - base), 64'd1);
        bus_read("y_hi_b2", SEL_RY_HI, 9'd2, 32'h4034_0000, 3);
        chk("y_hi_b2_rd_sel", 64'(last_rd_sel), 64'd1);
        rd_data = 64'h0123_4567_89AB_CDEF;
        bus_read("y_lo_b9", SEL_RY_LO, 9'd9, 32'h89AB_CDEF, 3);
        bus_read("y_hi_b9", SEL_RY_HI, 9'd9, 32'h0123_4567, 0);

        // Shadow dropped when host releases the result RAM
        bus_write(SEL_READ, 9'd0, 32'd0);
        bus_write(SEL_READ, 9'd0, 32'd1);
        bus_read("y_hi_b9_inv", SEL_RY_HI, 9'd9, 32'h0123_4567, 3);

        // Result reads without ownership
        bus_write(SEL_READ, 9'd0, 32'd0);
        base = rd_req_cnt;
        bus_read("noown_x_lo", SEL_RX_LO, 9'd2, 32'h0000_0000, 0);
        chk("noown_reqs", 64'(rd_req_cnt - base), 64'd0);

        // Shadow dropped when the core starts
        bus_write(SEL_READ, 9'd0, 32'd1);
        rd_data = 64'h4034_0000_0000_0000;
        bus_read("go_pre_x_lo", SEL_RX_LO, 9'd2, 32'h0000_0000, 3);
        bus_write(SEL_GO, 9'd0, 32'd1);
        bus_read("go_inv_x_hi", SEL_RX_HI, 9'd2, 32'h4034_0000, 3);
        bus_write(SEL_GO, 9'd0, 32'h8000_0000);

        // DONE readback
        done = 1'b1;
        bus_read("done_1", SEL_DONE, 9'd0, 32'd1, 0);
        done = 1'b0;
        bus_read("done_0", SEL_DONE, 9'd0, 32'd0, 0);

        // Read strobe dropped mid-fetch still fills the shadow
        rd_data = 64'hAABB_CCDD_1122_3344;
        base = rd_req_cnt;
        chipselect = 1'b1; read = 1'b1; write = 1'b0; addr = {SEL_RX_LO, 9'd7};
        tick();
        chipselect = 1'b0; read = 1'b0;
        repeat (3) tick();
        chk("drop_reqs", 64'(rd_req_cnt - base), 64'd1);
        bus_read("drop_x_hi_b7", SEL_RX_HI, 9'd7, 32'hAABB_CCDD, 0);

        // Reset during FETCH aborts the read and clears the shadow
        bus_write(SEL_GO, 9'd0, 32'd1);
        rd_data = 64'h4034_0000_0000_0000;
        bus_read("rst_pre_x_lo", SEL_RX_LO, 9'd2, 32'h0000_0000, 3);
        chipselect = 1'b1; read = 1'b1; write = 1'b0; addr = {SEL_RX_LO, 9'd3};
        tick();
        chk("fetch_wait", 64'(waitrequest), 64'd1);
        rst = 1'b0;
        #1;
        chk("rstf_waitrequest", 64'(waitrequest), 64'd0);
        chk("rstf_readdata", 64'(readdata), 64'd0);
        chk("rstf_go", 64'(go), 64'd0);
        chk("rstf_rd_req", 64'(rd_req), 64'd0);
        tick();
        rst = 1'b1;
        chipselect = 1'b0; read = 1'b0;
        tick();
        bus_write(SEL_READ, 9'd0, 32'd1);
        bus_read("rstf_x_hi_b2", SEL_RX_HI, 9'd2, 32'h4034_0000, 3);

        // Reset during a commit pulse cancels it and drops the stage
        bus_write(SEL_X_LO, 9'd10, 32'h0000_0001);
        chipselect = 1'b1; write = 1'b1; addr = {SEL_X_HI, 9'd10}; writedata = 32'h0000_0002;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chipselect = 1'b0; write = 1'b0;
        #1;
        chk("rstc_mem_we", 64'(mem_we), 64'd0);
        tick();
        rst = 1'b1;
        repeat (2) tick();
        chk("rstc_err", 64'(err), 64'd0);
        bus_write(SEL_X_HI, 9'd10, 32'h0000_0002);
        chk("rstc_stage_gone", 64'(err), 64'd1);
        clear_err();

        repeat (3) tick();
        chk("commit_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
